alu16_seq_ctrl: RTL and testbench
=================================

# alu16_seq_ctrl

Command sequencer in front of the ALU16 datapath. Accepts one operation at a time over a valid/ready command port and drives the ALU's A/B/op inputs. It returns the result over a valid/ready response port. Single-cycle ops (codes 0–11) pass through in one execute cycle. Code 12, unsigned division, is sequenced by the block as a 16-iteration non-restoring loop that uses only the ALU's ADD (0) and SUB (1) ops, which replaces the free-running divider.

## Interface
- DIV_ITER, 16, number of division iterations; only 16 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- cmd_op  in  4  operation code; ALU16 encoding for 0–11, 12 = sequenced divide, 13–15 illegal.
- cmd_a  in  16  operand A; the dividend for code 12.
- cmd_b  in  16  operand B; the divisor for code 12.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_op  out  4  ALU op select; 15 (ALU outputs 0) when not executing.
- alu_out  in  16  ALU result, combinational from alu_a/alu_b/alu_op.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  16  ALU result, or the quotient for code 12.
- rsp_rem  out  16  remainder for code 12; 0 otherwise.
- rsp_zero  out  1  rsp_result == 0; computed by this block, ALU zero flag unused.
- rsp_err  out  1  illegal op or illegal divisor.

## Operation
- States: IDLE, PASS, DIV, FIX, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch op/a/b.
  - Next state: PASS for codes 0–11, DIV for code 12 with divisor in 1..0x3FFF, RESP with err = 1 otherwise.
- PASS:
  - Drive alu_a = A, alu_b = B, alu_op = op.
  - At the clock edge, capture rsp_result = alu_out, rsp_rem = 0, zero = (alu_out == 0), err = 0. Next state RESP.
- DIV:
  - Initialise R = 0, Q = dividend, M = divisor, counter = DIV_ITER.
  - Each cycle: alu_a = {R[14:0], Q[15]}, alu_b = M, alu_op = R[15] ? 0 : 1.
  - At the edge: R <= alu_out, Q <= {Q[14:0], ~alu_out[15]}, decrement the counter.
  - After 16 iterations go to FIX.
- FIX:
  - Always exactly one cycle.
  - If R[15]: alu_a = R, alu_b = M, alu_op = 0, and R <= alu_out. Otherwise alu_op = 15 and R is held.
  - Capture rsp_result = Q, rsp_rem = R (final), zero = (Q == 0), err = 0. Next state RESP.
- Why the divisor is limited to 0x3FFF: it keeps the partial remainder within [-M, M) and the shifted remainder within 16-bit signed range, so the 16-bit ALU never overflows.
- Illegal cases (divisor 0, divisor ≥ 0x4000, op 13–15): rsp_result = 0, rsp_rem = 0, rsp_zero = 0, rsp_err = 1.
- RESP:
  - rsp_valid = 1; the data is held stable until rsp_valid && rsp_ready.
  - Then go to IDLE.
- Outside PASS, DIV and FIX: alu_op = 15, alu_a = alu_b = 0.

## Timing
- Reset:
  - Takes effect at the clock edge while reset is high.
  - State = IDLE, rsp_valid = 0, rsp_result = rsp_rem = 0, rsp_zero = rsp_err = 0, alu_op = 15, alu_a = alu_b = 0.
  - cmd_ready is 0 while reset is high and 1 from the first cycle after release.
- Reset mid-operation (any state): the command is aborted, no response is issued, and the block is in IDLE the next cycle.
- Latency, accept edge T to rsp_valid high:
  - Codes 0–11: T+2 cycles (PASS at T+1).
  - Code 12: T+18 cycles (DIV at T+1..T+16, FIX at T+17).
  - Illegal command: T+1 cycles.
- No overlap between commands. cmd_ready rises the cycle after the response handshake.
- Best throughput, with rsp_ready held high:
  - Pass ops: one command per 3 cycles.
  - Divide: one command per 19 cycles.
- cmd_valid while busy is ignored and does not need to be held stable; only IDLE samples the command.
- A response handshake in the same cycle as cmd_valid is legal: the command is accepted on the next IDLE cycle.
- alu_out is sampled only in PASS, DIV and FIX.

## Test plan
- Add: op 0, A = 0x0005, B = 0x0003 → rsp_result = 0x0008, zero = 0, err = 0, rsp_valid 2 cycles after accept, alu_op = 0 in exactly one cycle.
- Subtract to zero: op 1, A = 0x0007, B = 0x0007 → rsp_result = 0x0000, rsp_zero = 1.
- Divide, small operands: op 12, A = 0x0064, B = 0x0007 → rsp_result = 0x000E, rsp_rem = 0x0002, valid 18 cycles after accept. alu_op is 0 or 1 on 16 DIV cycles.
- Divide, extreme operands: op 12, A = 0xFFFF, B = 0x3FFF → quotient 0x0004, remainder 0x0003. Also A = 0x0003, B = 0x0010 → quotient 0, remainder 3, zero = 1.
- Errors:
  - op 12 with B = 0x0000, then B = 0x4000, then op 13 → each gives err = 1, result 0, valid 1 cycle after accept.
  - No alu_op other than 15 is driven for any of these.
- Backpressure and reset:
  - Hold rsp_ready low for 5 cycles → rsp_* stable, cmd_ready = 0.
  - Assert reset during the 8th DIV iteration → next cycle IDLE, rsp_valid = 0, cmd_ready = 1 after release, and the following add completes normally.

Source files
------------

// File: rtl/alu16_seq_ctrl.sv
// rtl/alu16_seq_ctrl.sv - command sequencer for ALU16 with a 16-step non-restoring divide
module alu16_seq_ctrl #(
  parameter int DIV_ITER = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [15:0] rsp_rem,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam int         CW     = $clog2(DIV_ITER + 1);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_DIV = 4'd12;
  localparam logic [3:0] OP_NOP = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_PASS, S_DIV, S_FIX, S_RESP} state_t;

  state_t        state;
  logic [3:0]    op_q;
  logic [15:0]   a_q;     // operand A, shifts into the quotient during DIV
  logic [15:0]   b_q;     // operand B, the divisor M during DIV/FIX
  logic [15:0]   r_q;     // signed partial remainder
  logic [CW-1:0] iter_q;
  logic [15:0]   fix_rem;

  assign cmd_ready = (state == S_IDLE) && !reset;
  assign fix_rem   = r_q[15] ? alu_out : r_q;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_NOP;
    case (state)
      S_PASS: begin
        alu_a  = a_q;
        alu_b  = b_q;
        alu_op = op_q;
      end
      S_DIV: begin
        alu_a  = {r_q[14:0], a_q[15]};
        alu_b  = b_q;
        alu_op = r_q[15] ? OP_ADD : OP_SUB;
      end
      S_FIX: begin
        // a negative final remainder gets M added back once
        if (r_q[15]) begin
          alu_a  = r_q;
          alu_b  = b_q;
          alu_op = OP_ADD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      r_q        <= '0;
      iter_q     <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_rem    <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            r_q    <= '0;
            iter_q <= CW'(DIV_ITER);
            if (cmd_op <= 4'd11) begin
              state <= S_PASS;
            end else if (cmd_op == OP_DIV && cmd_b != 16'h0000 && cmd_b < 16'h4000) begin
              state <= S_DIV;
            end else begin
              rsp_result <= '0;
              rsp_rem    <= '0;
              rsp_zero   <= 1'b0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= S_RESP;
            end
          end
        end
        S_PASS: begin
          rsp_result <= alu_out;
          rsp_rem    <= '0;
          rsp_zero   <= (alu_out == 16'h0000);
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_DIV: begin
          r_q    <= alu_out;
          a_q    <= {a_q[14:0], ~alu_out[15]};
          iter_q <= iter_q - CW'(1);
          if (iter_q == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          r_q        <= fix_rem;
          rsp_result <= a_q;
          rsp_rem    <= fix_rem;
          rsp_zero   <= (a_q == 16'h0000);
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq_ctrl.sv
// tb/tb_alu16_seq_ctrl.sv - bench for alu16_seq_ctrl with a behavioural ALU16 and divide model
module tb_alu16_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result, rsp_rem;
  logic        rsp_zero, rsp_err;

  int errors = 0;
  int checks = 0;
  int alu_cnt = 0;
  int addsub_cnt = 0;

  always #5 clk = ~clk;

  alu16_seq_ctrl #(.DIV_ITER(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_rem(rsp_rem),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a << 1;
      4'd7:    return a >> 1;
      4'd8:    return 16'($signed(a) >>> 1);
      4'd9:    return a + 16'd1;
      4'd10:   return a - 16'd1;
      4'd11:   return b;
      default: return 16'h0000;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_op, alu_a, alu_b);

  always @(negedge clk) begin
    if (alu_op != 4'hF) begin
      alu_cnt++;
      if (alu_op <= 4'd1) addsub_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res, output logic [15:0] rem,
                       output logic z, output logic e, output int lat);
    if (op <= 4'd11) begin
      res = alu_fn(op, a, b); rem = 16'h0; z = (res == 16'h0); e = 1'b0; lat = 2;
    end else if (op == 4'd12 && b != 16'h0 && b < 16'h4000) begin
      res = a / b; rem = a % b; z = (res == 16'h0); e = 1'b0; lat = 18;
    end else begin
      res = 16'h0; rem = 16'h0; z = 1'b0; e = 1'b1; lat = 1;
    end
  endtask

  // Issues one command, returns at the negedge where rsp_valid is first seen.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, output int lat);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    chk("accept_wait", 32'(w < 100), 32'd1);
    @(posedge clk);
    alu_cnt = 0; addsub_cnt = 0;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      cmd_valid = 1'b1; cmd_op = 4'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_txn(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] er, input logic [15:0] em, input logic ez, input logic ee, input int el);
    int lat;
    issue(op, a, b, lat);
    chk($sformatf("%s latency", tag), 32'(lat), 32'(el));
    chk($sformatf("%s result", tag), 32'(rsp_result), 32'(er));
    chk($sformatf("%s rem", tag), 32'(rsp_rem), 32'(em));
    chk($sformatf("%s zero", tag), 32'(rsp_zero), 32'(ez));
    chk($sformatf("%s err", tag), 32'(rsp_err), 32'(ee));
    if (el == 2) chk($sformatf("%s alu_cycles", tag), 32'(alu_cnt), 32'd1);
    if (el == 1) chk($sformatf("%s alu_cycles", tag), 32'(alu_cnt), 32'd0);
    if (el == 18) begin
      chk($sformatf("%s non_addsub", tag), 32'(alu_cnt - addsub_cnt), 32'd0);
      chk($sformatf("%s addsub_range", tag), 32'(addsub_cnt >= 16 && addsub_cnt <= 17), 32'd1);
    end
    if (rsp_ready) begin
      @(negedge clk);
      chk($sformatf("%s ready_after", tag), 32'(cmd_ready), 32'd1);
      chk($sformatf("%s valid_drop", tag), 32'(rsp_valid), 32'd0);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, res, rem;
    logic        z, e;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [15:0] r, m, hold_r, hold_m;
    logic z, e, hold_z;
    logic [3:0] op;
    logic [15:0] a, b;
    int lat, cnt;

    vecs[0]  = '{4'd0,  16'h0005, 16'h0003, 16'h0008, 16'h0000, 1'b0, 1'b0, 2};
    vecs[1]  = '{4'd1,  16'h0007, 16'h0007, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[2]  = '{4'd2,  16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 1'b0, 1'b0, 2};
    vecs[3]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 2};
    vecs[4]  = '{4'd12, 16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 18};
    vecs[5]  = '{4'd12, 16'hFFFF, 16'h3FFF, 16'h0004, 16'h0003, 1'b0, 1'b0, 18};
    vecs[6]  = '{4'd12, 16'h0003, 16'h0010, 16'h0000, 16'h0003, 1'b1, 1'b0, 18};
    vecs[7]  = '{4'd12, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18};
    vecs[8]  = '{4'd12, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'd12, 16'h1234, 16'h4000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[10] = '{4'd13, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[11] = '{4'd8,  16'h8000, 16'h1111, 16'hC000, 16'h0000, 1'b0, 1'b0, 2};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_a = 16'h0; cmd_b = 16'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_result", 32'(rsp_result), 32'd0);
    chk("reset rsp_rem", 32'(rsp_rem), 32'd0);
    chk("reset flags", 32'({rsp_zero, rsp_err}), 32'd0);
    chk("reset alu_op", 32'(alu_op), 32'hF);
    chk("reset alu_ab", 32'({alu_a, alu_b}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 12; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].rem, vecs[i].z, vecs[i].e, vecs[i].lat);

    // Backpressure: response must hold while rsp_ready is low
    rsp_ready = 1'b0;
    model(4'd12, 16'd1000, 16'd33, r, m, z, e, lat);
    check_txn("bp", 4'd12, 16'd1000, 16'd33, r, m, z, e, lat);
    hold_r = rsp_result; hold_m = rsp_rem; hold_z = rsp_zero;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d stable", i), {rsp_result, rsp_rem}, {hold_r, hold_m});
      chk($sformatf("bp%0d zero", i), 32'(rsp_zero), 32'(hold_z));
      chk($sformatf("bp%0d cmd_ready", i), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp ready_after", 32'(cmd_ready), 32'd1);

    // Reset during the 8th DIV iteration
    cmd_valid = 1'b1; cmd_op = 4'd12; cmd_a = 16'hBEEF; cmd_b = 16'h0123;
    chk("rst_div ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("rst_div in_div", 32'(alu_op <= 4'd1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_div valid", 32'(rsp_valid), 32'd0);
    chk("rst_div cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
    chk("rst_div alu_op", 32'(alu_op), 32'hF);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_div idle_ready", 32'(cmd_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    chk("rst_div no_response", 32'(cnt), 32'd0);
    check_txn("post_rst add", 4'd0, 16'h0005, 16'h0003, 16'h0008, 16'h0000, 1'b0, 1'b0, 2);

    // Randomised commands against the arithmetic model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) < 4) op = 4'd12;
      else op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      case ($urandom_range(0, 9))
        0:       b = 16'h0000;
        1:       b = 16'($urandom_range(16'h4000, 16'hFFFF));
        2:       b = 16'($urandom_range(1, 15));
        default: b = 16'($urandom_range(1, 16'h3FFF));
      endcase
      model(op, a, b, r, m, z, e, lat);
      check_txn($sformatf("rnd%0d op%0d a%0h b%0h", i, op, a, b), op, a, b, r, m, z, e, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
